// File: rtl/ara_inval_arbiter_pkg.sv
// Shared types and helpers for the multi-port AXI write invalidation arbiter.
package ara_inval_arbiter_pkg;

  localparam int unsigned MaxAddrWidth = 64;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [0:0] {
    WalkIdle   = 1'b0,
    WalkActive = 1'b1
  } walk_state_e;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] start_addr;
    logic [MaxAddrWidth-1:0] end_addr;
  } inval_desc_t;

  function automatic logic [MaxAddrWidth-1:0] line_align(input logic [MaxAddrWidth-1:0] addr,
                                                         input int unsigned line_width);
    return addr & ~(64'(line_width) - 64'd1);
  endfunction

endpackage

// File: rtl/ara_inval_arbiter_if.sv
// Sniffed AW channels plus the CVA6 invalidation handshake.
interface ara_inval_arbiter_if #(
  parameter int unsigned NrPorts   = 4,
  parameter int unsigned AddrWidth = 64
);
  logic [NrPorts-1:0]                aw_valid;
  logic [NrPorts-1:0]                aw_ready;
  logic [NrPorts-1:0][AddrWidth-1:0] aw_addr;
  logic [NrPorts-1:0][7:0]           aw_len;
  logic [NrPorts-1:0][2:0]           aw_size;
  logic [NrPorts-1:0][1:0]           aw_burst;
  logic [NrPorts-1:0]                aw_stall;
  logic [AddrWidth-1:0]              inval_addr;
  logic                              inval_valid;
  logic                              inval_ready;

  modport master (
    output aw_valid, aw_ready, aw_addr, aw_len, aw_size, aw_burst, inval_ready,
    input  aw_stall, inval_addr, inval_valid
  );

  modport slave (
    input  aw_valid, aw_ready, aw_addr, aw_len, aw_size, aw_burst, inval_ready,
    output aw_stall, inval_addr, inval_valid
  );
endinterface

// File: rtl/ara_inval_queue.sv
// Per-port descriptor FIFO; a push into a full queue survives only if a pop frees a slot that cycle.
module ara_inval_queue
  import ara_inval_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  inval_desc_t desc_i,
  input  logic        pop_i,
  output inval_desc_t desc_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        drop_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  inval_desc_t     mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic            push_s, pop_s;

  assign pop_s  = pop_i & ~empty_q;
  assign push_s = push_i & (~full_q | pop_s);
  assign drop_o = push_i & full_q & ~pop_s;

  always_comb begin
    cnt_d = cnt_q;
    if (push_s && !pop_s) begin
      cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push_s) wr_q <= wr_q + PtrW'(1);
      if (pop_s)  rd_q <= rd_q + PtrW'(1);
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == DepthCnt);
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_q] <= desc_i;
  end

  assign desc_o  = mem_q[rd_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
endmodule

// File: rtl/ara_inval_arbiter.sv
// Expands captured AW bursts into L1-line invalidations and walks them round-robin onto CVA6.
module ara_inval_arbiter
  import ara_inval_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned FifoDepth   = 4,
  parameter bit          CoalesceEn  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  ara_inval_arbiter_if.slave bus,
  output logic busy_o,
  output logic overflow_o
);
  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);

  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
    return IdxW'(v % NrPorts);
  endfunction

  function automatic inval_desc_t calc_span(input logic [AddrWidth-1:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [AddrWidth-1:0] bytes, first, last;
    inval_desc_t d;
    bytes = (AddrWidth'(len) + AddrWidth'(1)) << size;
    case (burst)
      BurstFixed: begin first = addr; last = addr; end
      BurstWrap: begin
        first = addr & ~(bytes - AddrWidth'(1));
        last  = first + bytes - AddrWidth'(1);
      end
      default: begin first = addr; last = addr + bytes - AddrWidth'(1); end
    endcase
    d.start_addr = line_align(MaxAddrWidth'(first), L1LineWidth);
    d.end_addr   = line_align(MaxAddrWidth'(last), L1LineWidth);
    return d;
  endfunction

  logic [NrPorts-1:0] capture_s, pop_s, empty_s, full_s, drop_s;
  inval_desc_t        span_s [NrPorts];
  inval_desc_t        head_s [NrPorts];
  logic               gnt_vld_s;
  logic [IdxW-1:0]    gnt_idx_s, rr_q, rr_d;
  logic [AddrWidth-1:0] head_start_s, head_end_s;
  logic [AddrWidth-1:0] cur_q, cur_d, end_q, end_d, last_q, last_d;
  logic               last_vld_q, last_vld_d, overflow_q;
  walk_state_e        state_q, state_d;

  assign capture_s = bus.aw_valid & bus.aw_ready & {NrPorts{en_i}};

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
    assign span_s[gi] = calc_span(bus.aw_addr[gi], bus.aw_len[gi], bus.aw_size[gi], bus.aw_burst[gi]);

    ara_inval_queue #(.Depth(FifoDepth)) u_queue (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (capture_s[gi]),
      .desc_i (span_s[gi]),
      .pop_i  (pop_s[gi]),
      .desc_o (head_s[gi]),
      .empty_o(empty_s[gi]),
      .full_o (full_s[gi]),
      .drop_o (drop_s[gi])
    );
  end

  // Round-robin: the lowest offset from rr_q wins, so iterate from the far end down.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = int'(NrPorts) - 1; k >= 0; k--) begin
      if (!empty_s[wrap_idx(32'(rr_q) + 32'(k))]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = wrap_idx(32'(rr_q) + 32'(k));
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  assign head_start_s = AddrWidth'(head_s[gnt_idx_s].start_addr);
  assign head_end_s   = AddrWidth'(head_s[gnt_idx_s].end_addr);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    rr_d       = rr_q;
    pop_s      = '0;
    case (state_q)
      WalkIdle: begin
        if (gnt_vld_s) begin
          pop_s[gnt_idx_s] = 1'b1;
          rr_d  = wrap_idx(32'(gnt_idx_s) + 32'd1);
          end_d = head_end_s;
          if (CoalesceEn && last_vld_q && (head_start_s == last_q)) begin
            // The first line was just invalidated; skip it, or drop a one-line burst entirely.
            if (head_start_s != head_end_s) begin
              cur_d   = head_start_s + LineStep;
              state_d = WalkActive;
            end else begin
              state_d = WalkIdle;
            end
          end else begin
            cur_d   = head_start_s;
            state_d = WalkActive;
          end
        end else begin
          last_vld_d = 1'b0;
        end
      end
      WalkActive: begin
        if (bus.inval_ready) begin
          last_d     = cur_q;
          last_vld_d = 1'b1;
          if (cur_q == end_q) begin
            state_d = WalkIdle;
          end else begin
            cur_d = cur_q + LineStep;
          end
        end else begin
          state_d = WalkActive;
        end
      end
      default: state_d = WalkIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WalkIdle;
      cur_q      <= '0;
      end_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_q | (|drop_s);
    end
  end

  assign bus.inval_valid = (state_q == WalkActive);
  assign bus.inval_addr  = cur_q;
  assign bus.aw_stall    = full_s;
  assign busy_o          = (|(~empty_s)) | (state_q == WalkActive);
  assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_ara_inval_arbiter.sv
// Directed bench for ara_inval_arbiter: 4 ports, 16-byte lines, 4-deep queues.
module tb_ara_inval_arbiter;
  logic clk, rst, en, busy, overflow;
  int   total = 0;
  int   bad   = 0;

  ara_inval_arbiter_if #(.NrPorts(4), .AddrWidth(64)) bus ();

  ara_inval_arbiter #(
    .NrPorts(4), .AddrWidth(64), .L1LineWidth(16), .FifoDepth(4), .CoalesceEn(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bus(bus), .busy_o(busy), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_aw(input int p, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.aw_addr[p]  = addr;
    bus.aw_len[p]   = len;
    bus.aw_size[p]  = size;
    bus.aw_burst[p] = burst;
    bus.aw_valid[p] = 1'b1;
  endtask

  task automatic capture(input int p, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    set_aw(p, addr, len, size, burst);
    tick();
    bus.aw_valid = 4'b0000;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [63:0] addr);
    check_eq({tag, "_valid"}, 64'(bus.inval_valid), 64'(vld));
    if (vld) check_eq({tag, "_addr"}, bus.inval_addr, addr);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b1;
    bus.aw_valid = 4'b0000; bus.aw_ready = 4'b1111;
    bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.inval_ready = 1'b1;
    tick(); tick();
    check_eq("rst_valid", 64'(bus.inval_valid), 64'd0);
    check_eq("rst_addr", bus.inval_addr, 64'd0);
    check_eq("rst_stall", 64'(bus.aw_stall), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();

    // INCR spanning three lines, first at capture+2
    capture(0, 64'h8000_0008, 8'd3, 3'd3, 2'b01);
    check_eq("incr_lat1", 64'(bus.inval_valid), 64'd0);
    check_eq("incr_busy", 64'(busy), 64'd1);
    tick(); check_out("incr0", 1'b1, 64'h8000_0000);
    tick(); check_out("incr1", 1'b1, 64'h8000_0010);
    tick(); check_out("incr2", 1'b1, 64'h8000_0020);
    tick(); check_out("incr_end", 1'b0, 64'd0);

    // FIXED -> single line
    capture(0, 64'h8000_0104, 8'd7, 3'd2, 2'b00);
    tick(); check_out("fixed", 1'b1, 64'h8000_0100);
    tick(); check_out("fixed_end", 1'b0, 64'd0);

    // ports 1 and 2 together, twice; pointer goes 1->2->3 so port 1 leads both rounds
    for (int r = 0; r < 2; r++) begin
      set_aw(1, 64'h9000_0000, 8'd0, 3'd0, 2'b01);
      set_aw(2, 64'hA000_0000, 8'd0, 3'd0, 2'b01);
      tick();
      bus.aw_valid = 4'b0000;
      tick(); check_out("rr_first", 1'b1, 64'h9000_0000);
      tick(); check_out("rr_bubble", 1'b0, 64'd0);
      tick(); check_out("rr_second", 1'b1, 64'hA000_0000);
      tick(); check_out("rr_end", 1'b0, 64'd0);
    end

    // back-pressure hold plus port 3 queue fill and overflow
    bus.inval_ready = 1'b0;
    capture(0, 64'h8000_0200, 8'd1, 3'd4, 2'b01);
    tick(); check_out("hold_start", 1'b1, 64'h8000_0200);
    for (int k = 0; k < 5; k++) begin
      capture(3, 64'hB000_0000 + 64'(k) * 64'h100, 8'd0, 3'd0, 2'b01);
      check_out("hold", 1'b1, 64'h8000_0200);
      if (k == 2) check_eq("stall_3rd", 64'(bus.aw_stall[3]), 64'd0);
      if (k == 3) check_eq("stall_4th", 64'(bus.aw_stall[3]), 64'd1);
      if (k == 3) check_eq("ovf_4th", 64'(overflow), 64'd0);
      if (k == 4) check_eq("ovf_5th", 64'(overflow), 64'd1);
    end
    bus.inval_ready = 1'b1;
    tick(); check_out("hold_next", 1'b1, 64'h8000_0210);
    tick(); check_out("hold_idle", 1'b0, 64'd0);
    check_eq("stall_kept", 64'(bus.aw_stall[3]), 64'd1);
    tick(); check_out("drain0", 1'b1, 64'hB000_0000);
    check_eq("stall_freed", 64'(bus.aw_stall[3]), 64'd0);
    for (int k = 1; k < 4; k++) begin
      tick(); check_out("drain_bubble", 1'b0, 64'd0);
      tick(); check_out("drain", 1'b1, 64'hB000_0000 + 64'(k) * 64'h100);
    end
    tick(); check_out("drain_end", 1'b0, 64'd0);
    check_eq("drain_busy", 64'(busy), 64'd0);

    // coalescing: identical one-line bursts, then a two-line burst whose first line repeats
    capture(0, 64'h8000_0010, 8'd0, 3'd4, 2'b01);
    capture(0, 64'h8000_0010, 8'd0, 3'd4, 2'b01);
    check_out("coal_a", 1'b1, 64'h8000_0010);
    tick(); check_out("coal_a_idle", 1'b0, 64'd0);
    tick(); check_out("coal_a_drop", 1'b0, 64'd0);
    check_eq("coal_a_busy", 64'(busy), 64'd0);
    capture(0, 64'h8000_0300, 8'd0, 3'd4, 2'b01);
    capture(0, 64'h8000_0300, 8'd1, 3'd4, 2'b01);
    check_out("coal_b0", 1'b1, 64'h8000_0300);
    tick(); check_out("coal_b_idle", 1'b0, 64'd0);
    tick(); check_out("coal_b1", 1'b1, 64'h8000_0310);
    tick(); check_out("coal_b_end", 1'b0, 64'd0);
    check_eq("coal_b_busy", 64'(busy), 64'd0);

    // disabled: no capture
    en = 1'b0;
    capture(2, 64'hE000_0000, 8'd0, 3'd0, 2'b01);
    check_eq("dis_busy0", 64'(busy), 64'd0);
    tick(); check_out("dis", 1'b0, 64'd0);
    check_eq("dis_busy1", 64'(busy), 64'd0);
    en = 1'b1;

    // WRAP 64 B container at 0x8000_0000
    capture(1, 64'h8000_0038, 8'd7, 3'd3, 2'b10);
    for (int k = 0; k < 4; k++) begin
      tick(); check_out("wrap", 1'b1, 64'h8000_0000 + 64'(k) * 64'h10);
    end
    tick(); check_out("wrap_end", 1'b0, 64'd0);

    // reset mid-walk with queued work and sticky overflow pending
    capture(0, 64'h8000_0400, 8'd3, 3'd4, 2'b01);
    tick(); check_out("mid_walk", 1'b1, 64'h8000_0400);
    bus.inval_ready = 1'b0;
    capture(1, 64'hF000_0000, 8'd0, 3'd0, 2'b01);
    capture(1, 64'hF000_0100, 8'd0, 3'd0, 2'b01);
    rst = 1'b1;
    tick();
    check_eq("rst2_valid", 64'(bus.inval_valid), 64'd0);
    check_eq("rst2_addr", bus.inval_addr, 64'd0);
    check_eq("rst2_stall", 64'(bus.aw_stall), 64'd0);
    check_eq("rst2_busy", 64'(busy), 64'd0);
    check_eq("rst2_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    bus.inval_ready = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_out("post_rst", 1'b0, 64'd0);
    set_aw(0, 64'hD000_0000, 8'd0, 3'd0, 2'b01);
    set_aw(3, 64'hC000_0000, 8'd0, 3'd0, 2'b01);
    tick();
    bus.aw_valid = 4'b0000;
    tick(); check_out("post_rst_p0", 1'b1, 64'hD000_0000);
    tick(); check_out("post_rst_bubble", 1'b0, 64'd0);
    tick(); check_out("post_rst_p3", 1'b1, 64'hC000_0000);
    tick(); check_out("post_rst_end", 1'b0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
